// File: rtl/fpnew_issue_scheduler.sv
// fpnew_issue_scheduler: shares one FPU between NumReq requesters.
// Round-robin issue with a grant lock under backpressure, requester index
// used as the FPU tag, tag-based response routing, and per-requester
// outstanding counters that cap in-flight work.
module fpnew_issue_scheduler #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned ReqWidth       = 256,
  parameter int unsigned RspWidth       = 69,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth      = $clog2(NumReq),
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  output logic                               flush_o,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq-1:0][ReqWidth-1:0]    req_data_i,
  output logic                               fpu_in_valid_o,
  input  logic                               fpu_in_ready_i,
  output logic [ReqWidth-1:0]                fpu_req_data_o,
  output logic [IdxWidth-1:0]                fpu_tag_o,
  input  logic                               fpu_out_valid_i,
  output logic                               fpu_out_ready_o,
  input  logic [RspWidth-1:0]                fpu_rsp_data_i,
  input  logic [IdxWidth-1:0]                fpu_tag_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [NumReq-1:0][RspWidth-1:0]    rsp_data_o,
  output logic                               busy_o,
  output logic                               err_o
);

  logic [IdxWidth-1:0] r_rr;
  logic                r_lock;
  logic [IdxWidth-1:0] r_lock_idx;
  logic [CntWidth-1:0] r_cnt [NumReq];
  logic                r_err;

  logic [NumReq-1:0]   w_elig;
  logic [NumReq-1:0]   w_inc;
  logic [NumReq-1:0]   w_dec;
  logic                w_any_elig;
  logic                w_rr_found;
  logic [IdxWidth-1:0] w_rr_idx;
  logic [IdxWidth-1:0] w_grant;
  logic [IdxWidth-1:0] w_rsp_idx;
  logic                w_issue;
  logic                w_tag_bad;
  logic                w_rsp_fire;
  logic                w_underflow;

  // (base + off) mod NumReq; both operands are already below NumReq.
  function automatic logic [IdxWidth-1:0] wrap_add(input logic [IdxWidth-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdxWidth'(sum);
  endfunction

  // Eligibility: request pending and a free outstanding slot.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NumReq; i++)
      w_elig[i] = req_valid_i[i] && (r_cnt[i] < CntWidth'(MaxOutstanding));
  end

  // Round-robin search: first eligible index at or after r_rr.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!w_rr_found && w_elig[wrap_add(r_rr, k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = wrap_add(r_rr, k);
      end
    end
  end

  // A stalled grant is re-presented until it handshakes.
  assign w_any_elig     = |w_elig;
  assign w_grant        = (r_lock && w_elig[r_lock_idx]) ? r_lock_idx : w_rr_idx;
  assign w_issue        = w_any_elig && fpu_in_ready_i;
  assign fpu_in_valid_o = w_any_elig;
  assign fpu_tag_o      = w_grant;
  assign fpu_req_data_o = req_data_i[w_grant];
  assign flush_o        = flush_i;

  // Ready goes back only to the granted requester.
  always_comb begin
    req_ready_o = '0;
    if (w_any_elig) req_ready_o[w_grant] = fpu_in_ready_i;
  end

  // Out-of-range tags are drained and dropped rather than routed.
  assign w_tag_bad       = (32'(fpu_tag_i) >= NumReq);
  assign w_rsp_idx       = w_tag_bad ? '0 : fpu_tag_i;
  assign fpu_out_ready_o = w_tag_bad | rsp_ready_i[w_rsp_idx];
  assign w_rsp_fire      = fpu_out_valid_i && fpu_out_ready_o;
  assign w_underflow     = w_rsp_fire && !w_tag_bad && !flush_i &&
                           (r_cnt[w_rsp_idx] == '0);

  // Response fan-out, per-lane counter events and the busy summary.
  always_comb begin
    rsp_valid_o = '0;
    rsp_data_o  = '0;
    w_inc       = '0;
    w_dec       = '0;
    busy_o      = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      rsp_valid_o[i] = fpu_out_valid_i && !w_tag_bad && (fpu_tag_i == IdxWidth'(i));
      rsp_data_o[i]  = fpu_rsp_data_i;
      w_inc[i]       = w_issue && (w_grant == IdxWidth'(i));
      w_dec[i]       = w_rsp_fire && !w_tag_bad && (w_rsp_idx == IdxWidth'(i)) &&
                       (r_cnt[i] != '0);
      busy_o         = busy_o | (r_cnt[i] != '0);
    end
  end

  assign err_o = r_err;

  // State update: pointer, grant lock, outstanding counters, sticky error.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ni) begin
      r_rr       <= '0;
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
      r_err      <= 1'b0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset explicitly; a real memory would not be.
      for (int i = 0; i < NumReq; i++) r_cnt[i] <= '0;
    end else begin
      if (w_issue) r_rr <= wrap_add(w_grant, 1);
      if ((w_rsp_fire && w_tag_bad) || w_underflow) r_err <= 1'b1;
      if (flush_i) begin
        r_lock <= 1'b0;
        for (int i = 0; i < NumReq; i++) r_cnt[i] <= '0;
      end else begin
        r_lock     <= w_any_elig && !fpu_in_ready_i;
        r_lock_idx <= w_grant;
        for (int i = 0; i < NumReq; i++) begin
          if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CntWidth'(1);
          else if (w_dec[i] && !w_inc[i]) r_cnt[i] <= r_cnt[i] - CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fpnew_issue_scheduler.sv
// Testbench for fpnew_issue_scheduler: directed scenario tasks plus a
// randomized run checked against a cycle-level behavioural model.
module tb_fpnew_issue_scheduler;
  localparam int N  = 4;
  localparam int RW = 16;
  localparam int SW = 12;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, flush, flush_o, in_valid, in_ready, out_valid, out_ready, busy, err;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][RW-1:0] req_data;
  logic [RW-1:0] fpu_data;
  logic [1:0] tag_o, tag_i;
  logic [SW-1:0] rsp_data;
  logic [N-1:0][SW-1:0] rsp_lanes;

  // Second instance with five requesters, used for out-of-range tags.
  logic b_flush_o, b_in_valid, b_out_valid, b_out_ready, b_busy, b_err;
  logic [4:0] b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [4:0][RW-1:0] b_req_data;
  logic [RW-1:0] b_fpu_data;
  logic [2:0] b_tag_o, b_tag_i;
  logic [4:0][SW-1:0] b_rsp_lanes;

  fpnew_issue_scheduler #(.NumReq(N), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .flush_o(flush_o),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
    .fpu_in_valid_o(in_valid), .fpu_in_ready_i(in_ready), .fpu_req_data_o(fpu_data),
    .fpu_tag_o(tag_o), .fpu_out_valid_i(out_valid), .fpu_out_ready_o(out_ready),
    .fpu_rsp_data_i(rsp_data), .fpu_tag_i(tag_i), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_lanes), .busy_o(busy), .err_o(err)
  );

  fpnew_issue_scheduler #(.NumReq(5), .ReqWidth(RW), .RspWidth(SW), .MaxOutstanding(MO)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(1'b0), .flush_o(b_flush_o),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_data_i(b_req_data),
    .fpu_in_valid_o(b_in_valid), .fpu_in_ready_i(1'b0), .fpu_req_data_o(b_fpu_data),
    .fpu_tag_o(b_tag_o), .fpu_out_valid_i(b_out_valid), .fpu_out_ready_o(b_out_ready),
    .fpu_rsp_data_i(rsp_data), .fpu_tag_i(b_tag_i), .rsp_valid_o(b_rsp_valid),
    .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_lanes), .busy_o(b_busy), .err_o(b_err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: plain integers, updated once per clock.
  int m_rr, m_lock, m_lock_idx, m_err;
  int m_cnt [N];
  // Expected combinational outputs for the current inputs.
  bit e_valid, e_out_ready, e_busy;
  int e_grant;
  logic [N-1:0] e_req_ready, e_rsp_valid;

  task automatic model_eval();
    bit elig [N];
    for (int i = 0; i < N; i++) elig[i] = req_valid[i] && (m_cnt[i] < MO);
    e_valid = 1'b0;
    e_grant = 0;
    if (m_lock != 0 && elig[m_lock_idx]) begin
      e_valid = 1'b1;
      e_grant = m_lock_idx;
    end else begin
      for (int k = 0; k < N; k++)
        if (!e_valid && elig[(m_rr + k) % N]) begin
          e_valid = 1'b1;
          e_grant = (m_rr + k) % N;
        end
    end
    e_req_ready = '0;
    if (e_valid && in_ready) e_req_ready[e_grant] = 1'b1;
    e_rsp_valid = '0;
    if (out_valid) e_rsp_valid[tag_i] = 1'b1;
    e_out_ready = rsp_ready[tag_i];
    e_busy = 1'b0;
    for (int i = 0; i < N; i++) if (m_cnt[i] > 0) e_busy = 1'b1;
  endtask

  // Advance one clock, updating the model from the pre-edge inputs.
  task automatic tick();
    bit issue, rsp;
    int g, t;
    model_eval();
    issue = e_valid && in_ready;
    rsp   = out_valid && e_out_ready;
    g     = e_grant;
    t     = int'(tag_i);
    @(posedge clk);
    if (!rst_n) begin
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_err = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      if (issue) m_rr = (g + 1) % N;
      if (flush) begin
        m_lock = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else begin
        m_lock     = (e_valid && !in_ready) ? 1 : 0;
        m_lock_idx = g;
        if (rsp) begin
          if (m_cnt[t] == 0) m_err = 1;
          else m_cnt[t] = m_cnt[t] - 1;
        end
        if (issue) m_cnt[g] = m_cnt[g] + 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; req_valid = '0; in_ready = 1'b0; out_valid = 1'b0; tag_i = '0;
    rsp_ready = '0; rsp_data = '0;
    b_req_valid = '0; b_out_valid = 1'b0; b_tag_i = '0; b_rsp_ready = '0;
    for (int i = 0; i < N; i++) req_data[i] = RW'(32'h1111 * (i + 1));
    for (int i = 0; i < 5; i++) b_req_data[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (in_valid !== 1'b0) begin n_mis++; $display("FAIL reset_in_valid: got %0b want 0", in_valid); end
    n_cmp++; if (req_ready !== 4'b0) begin n_mis++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_cmp++; if (rsp_valid !== 4'b0) begin n_mis++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_round_robin();
    int prev;
    do_reset();
    rsp_ready = '1; req_valid = '1; in_ready = 1'b1; prev = -1;
    for (int k = 0; k < 5; k++) begin
      out_valid = (prev >= 0);
      tag_i = (prev < 0) ? 2'd0 : 2'(prev);
      #1;
      n_cmp++; if (tag_o !== 2'(k % 4)) begin n_mis++; $display("FAIL rr_tag[%0d]: got %0d want %0d", k, tag_o, k % 4); end
      n_cmp++; if (req_ready !== 4'(1 << (k % 4))) begin n_mis++; $display("FAIL rr_ready[%0d]: got %b", k, req_ready); end
      if (prev >= 0) begin
        n_cmp++; if (rsp_valid !== 4'(1 << prev)) begin n_mis++; $display("FAIL rr_rsp_valid[%0d]: got %b", k, rsp_valid); end
      end
      prev = k % 4;
      tick();
    end
    req_valid = '0; in_ready = 1'b0; out_valid = 1'b1; tag_i = 2'(prev);
    tick();
    out_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rr_drain_busy: got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL rr_drain_err: got %0b want 0", err); end
  endtask

  task automatic test_lock();
    do_reset();
    req_valid = 4'b0100; in_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) req_valid = 4'b0101;
      #1;
      n_cmp++; if (tag_o !== 2'd2) begin n_mis++; $display("FAIL lock_tag[%0d]: got %0d want 2", k, tag_o); end
      n_cmp++; if (in_valid !== 1'b1) begin n_mis++; $display("FAIL lock_valid[%0d]: got %0b want 1", k, in_valid); end
      tick();
    end
    in_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_mis++; $display("FAIL lock_release_ready: got %b want 0100", req_ready); end
    tick();
    #1;
    n_cmp++; if (tag_o !== 2'd0) begin n_mis++; $display("FAIL lock_next_grant: got %0d want 0", tag_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_outstanding();
    do_reset();
    req_valid = 4'b0010; in_ready = 1'b1;
    for (int k = 0; k < MO; k++) begin
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_mis++; $display("FAIL outst_issue[%0d]: got %b want 0010", k, req_ready); end
      tick();
    end
    in_ready = 1'b0;
    #1;
    n_cmp++; if (in_valid !== 1'b0) begin n_mis++; $display("FAIL outst_full_valid: got %0b want 0", in_valid); end
    req_valid = 4'b0110; in_ready = 1'b1;
    #1;
    n_cmp++; if (tag_o !== 2'd2) begin n_mis++; $display("FAIL outst_skip_tag: got %0d want 2", tag_o); end
    n_cmp++; if (req_ready !== 4'b0100) begin n_mis++; $display("FAIL outst_skip_ready: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b0010; in_ready = 1'b0; out_valid = 1'b1; tag_i = 2'd1; rsp_ready = '1;
    #1;
    n_cmp++; if (in_valid !== 1'b0) begin n_mis++; $display("FAIL outst_same_cycle: got %0b want 0", in_valid); end
    n_cmp++; if (rsp_valid !== 4'b0010) begin n_mis++; $display("FAIL outst_rsp_valid: got %b want 0010", rsp_valid); end
    tick();
    out_valid = 1'b0; in_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_mis++; $display("FAIL outst_freed: got %b want 0010", req_ready); end
    tick();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    do_reset();
    req_valid = 4'b1000; in_ready = 1'b1;
    tick();
    req_valid = '0; in_ready = 1'b0; out_valid = 1'b1; tag_i = 2'd3; rsp_ready = 4'b0111;
    #1;
    n_cmp++; if (out_ready !== 1'b0) begin n_mis++; $display("FAIL stall_out_ready: got %0b want 0", out_ready); end
    n_cmp++; if (rsp_valid !== 4'b1000) begin n_mis++; $display("FAIL stall_rsp_valid: got %b want 1000", rsp_valid); end
    tick();
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL stall_hold_busy: got %0b want 1", busy); end
    req_valid = 4'b1000; in_ready = 1'b1; rsp_ready = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_mis++; $display("FAIL simul_req_ready: got %b want 1000", req_ready); end
    n_cmp++; if (out_ready !== 1'b1) begin n_mis++; $display("FAIL simul_out_ready: got %0b want 1", out_ready); end
    tick();
    req_valid = '0; in_ready = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL simul_count_kept: got busy %0b want 1", busy); end
    tick();
    out_valid = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL simul_drain_busy: got %0b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL simul_drain_err: got %0b want 0", err); end
  endtask

  task automatic test_error();
    do_reset();
    out_valid = 1'b1; tag_i = 2'd3; rsp_ready = '1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL err_before: got %0b want 0", err); end
    tick();
    out_valid = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL err_underflow: got %0b want 1", err); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL err_underflow_busy: got %0b want 0", busy); end
    repeat (3) tick();
    n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL err_sticky: got %0b want 1", err); end
    b_out_valid = 1'b1; b_tag_i = 3'd5; b_rsp_ready = '0;
    #1;
    n_cmp++; if (b_out_ready !== 1'b1) begin n_mis++; $display("FAIL badtag_out_ready: got %0b want 1", b_out_ready); end
    n_cmp++; if (b_rsp_valid !== 5'b0) begin n_mis++; $display("FAIL badtag_rsp_valid: got %b want 00000", b_rsp_valid); end
    n_cmp++; if (b_err !== 1'b0) begin n_mis++; $display("FAIL badtag_before: got %0b want 0", b_err); end
    tick();
    b_out_valid = 1'b0;
    #1;
    n_cmp++; if (b_err !== 1'b1) begin n_mis++; $display("FAIL badtag_err: got %0b want 1", b_err); end
    n_cmp++; if (b_busy !== 1'b0) begin n_mis++; $display("FAIL badtag_busy: got %0b want 0", b_busy); end
  endtask

  task automatic test_flush();
    do_reset();
    req_valid = 4'b0111; in_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++; if (tag_o !== 2'(k % 3)) begin n_mis++; $display("FAIL flush_fill[%0d]: got %0d want %0d", k, tag_o, k % 3); end
      tick();
    end
    req_valid = '0; in_ready = 1'b0; flush = 1'b1;
    #1;
    n_cmp++; if (flush_o !== 1'b1) begin n_mis++; $display("FAIL flush_o_high: got %0b want 1", flush_o); end
    n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL flush_busy_before: got %0b want 1", busy); end
    tick();
    flush = 1'b0;
    #1;
    n_cmp++; if (flush_o !== 1'b0) begin n_mis++; $display("FAIL flush_o_low: got %0b want 0", flush_o); end
    n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL flush_busy_after: got %0b want 0", busy); end
    req_valid = '1; in_ready = 1'b1;
    #1;
    n_cmp++; if (tag_o !== 2'd3) begin n_mis++; $display("FAIL flush_rr_kept: got %0d want 3", tag_o); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int t;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) req_data[i] = RW'($urandom);
      rsp_data  = SW'($urandom);
      req_valid = 4'($urandom);
      if (m_lock != 0) req_valid[m_lock_idx] = 1'b1;
      model_eval();
      in_ready  = e_valid && ($urandom_range(0, 2) != 0);
      out_valid = 1'b0;
      tag_i     = 2'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        t = $urandom_range(0, N - 1);
        if (m_cnt[t] > 0) begin out_valid = 1'b1; tag_i = 2'(t); end
      end
      rsp_ready = 4'($urandom);
      #1;
      model_eval();
      n_cmp++; if (in_valid !== e_valid) begin n_mis++; $display("FAIL rnd_valid[%0d]: got %0b want %0b", c, in_valid, e_valid); end
      if (e_valid) begin
        n_cmp++; if (tag_o !== 2'(e_grant)) begin n_mis++; $display("FAIL rnd_tag[%0d]: got %0d want %0d", c, tag_o, e_grant); end
        n_cmp++; if (fpu_data !== req_data[e_grant]) begin n_mis++; $display("FAIL rnd_data[%0d]: got %h want %h", c, fpu_data, req_data[e_grant]); end
      end
      n_cmp++; if (req_ready !== e_req_ready) begin n_mis++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", c, req_ready, e_req_ready); end
      n_cmp++; if (rsp_valid !== e_rsp_valid) begin n_mis++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", c, rsp_valid, e_rsp_valid); end
      n_cmp++; if (out_ready !== e_out_ready) begin n_mis++; $display("FAIL rnd_out_ready[%0d]: got %0b want %0b", c, out_ready, e_out_ready); end
      n_cmp++; if (rsp_lanes[c % N] !== rsp_data) begin n_mis++; $display("FAIL rnd_rsp_data[%0d]: got %h want %h", c, rsp_lanes[c % N], rsp_data); end
      n_cmp++; if (busy !== e_busy) begin n_mis++; $display("FAIL rnd_busy[%0d]: got %0b want %0b", c, busy, e_busy); end
      n_cmp++; if (err !== 1'(m_err)) begin n_mis++; $display("FAIL rnd_err[%0d]: got %0b want %0d", c, err, m_err); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_outstanding();
    test_same_cycle();
    test_error();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
